fir_tap_serializer: RTL

Parallel-to-serial converter for FIR tap vectors. It accepts one HWPE-Stream beat carrying NB_TAPS packed coefficients and emits them one word per handshake on a serial HWPE-Stream. It sits between a parallel coefficient source (register file or wide memory streamer) and any consumer that takes taps serially. It is the counterpart of the serial-to-parallel tap buffer feeding the FIR datapath.

---
 rtl/fir_tap_serializer_pkg.sv | 14 +
 rtl/fir_tap_serializer_if.sv | 15 +
 rtl/fir_tap_serializer.sv | 87 ++++++++
 3 files changed

// File: rtl/fir_tap_serializer_pkg.sv
// Shared types and helpers for the FIR tap parallel-to-serial converter.
package fir_tap_serializer_pkg;

    typedef enum logic {
        FIR_SER_IDLE   = 1'b0,
        FIR_SER_STREAM = 1'b1
    } fir_ser_state_t;

    // Counter width that stays at least one bit wide for single-tap builds.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_tap_serializer_if.sv
// HWPE-Stream style valid/ready channel; master drives data, slave returns ready.
interface fir_tap_serializer_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    localparam int unsigned STRB_WIDTH = (DATA_WIDTH + 7) / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport master (output valid, output data, output strb, input  ready);
    modport slave  (input  valid, input  data, input  strb, output ready);

endinterface

// File: rtl/fir_tap_serializer.sv
// Parallel-to-serial converter: one packed tap vector in, NB_TAPS words out,
// with a combinational reload path so consecutive vectors stream without a bubble.
module fir_tap_serializer
    import fir_tap_serializer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NB_TAPS    = 2,
    parameter bit          REVERSE    = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    fir_tap_serializer_if.slave  h_parallel,
    fir_tap_serializer_if.master h_serial,
    output logic                 done_o
);

    localparam int unsigned      CNT_W     = cnt_width(NB_TAPS);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NB_TAPS - 1);
    localparam logic [0:0]       ST_IDLE   = FIR_SER_IDLE;
    localparam logic [0:0]       ST_STREAM = FIR_SER_STREAM;

    logic [0:0]                         state_q;
    logic [CNT_W-1:0]                   cnt_q;
    logic [NB_TAPS-1:0][DATA_WIDTH-1:0] buf_q;

    logic             streaming;
    logic             last;
    logic [CNT_W-1:0] idx;
    logic             ser_hs;
    logic             par_ready;
    logic             par_hs;

    // A new vector may only be accepted when the buffer is empty or the final
    // word is leaving in this very cycle.
    always_comb begin
        streaming = (state_q == ST_STREAM);
        last      = (cnt_q == LAST_CNT);
        idx       = REVERSE ? (LAST_CNT - cnt_q) : cnt_q;
        ser_hs    = streaming & h_serial.ready;
        if (rst_i) begin
            par_ready = 1'b0;
        end else if (streaming) begin
            par_ready = last & h_serial.ready;
        end else begin
            par_ready = 1'b1;
        end
        par_hs = h_parallel.valid & par_ready;
    end

    assign h_parallel.ready = par_ready;
    assign h_serial.valid   = streaming;
    assign h_serial.data    = streaming ? buf_q[idx] : '0;
    assign h_serial.strb    = '1;
    assign done_o           = ser_hs & last & ~clear_i;

    // Reload takes precedence over returning to idle; in STREAM a parallel
    // handshake implies the final serial handshake is happening too.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else if (clear_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else if (par_hs) begin
            state_q <= ST_STREAM;
            cnt_q   <= '0;
            buf_q   <= h_parallel.data;
        end else if (ser_hs) begin
            if (last) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    par_width_chk: assert property (@(posedge clk_i)
        $bits(h_parallel.data) == NB_TAPS * DATA_WIDTH);
    ser_width_chk: assert property (@(posedge clk_i)
        $bits(h_serial.data) == DATA_WIDTH);

endmodule
